// File: rtl/puzzle_pkg.sv
// puzzle_pkg: shared constants and FSM state type for the 2x3 sliding puzzle move unit
package puzzle_pkg;
    localparam int WORD_W = 28;
    localparam int NPOS_C = 6;
    localparam logic [3:0] REG_CURRENT = 4'd0;
    localparam logic [3:0] REG_ANSWER  = 4'd1;
    localparam logic [3:0] REG_COUNTER = 4'd2;
    localparam logic [3:0] REG_COMPARE = 4'd3;
    localparam logic [1:0] DIR_UP      = 2'b00;
    localparam logic [1:0] DIR_DOWN    = 2'b01;
    localparam logic [1:0] DIR_LEFT    = 2'b10;
    localparam logic [1:0] DIR_RIGHT   = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_COUNT = 2'd2,
        ST_CMP   = 2'd3
    } state_t;
endpackage

// File: rtl/puzzle_move_unit_tile_swap.sv
// tile_swap: locates the blank, checks the move stays on the 2x3 grid and swaps blank with its neighbour
module tile_swap
    import puzzle_pkg::*;
#(
    parameter int W    = WORD_W,
    parameter int NPOS = NPOS_C
) (
    input  logic [W-1:0] st,
    input  logic [1:0]   dir,
    output logic [W-1:0] swapped,
    output logic         legal
);
    logic [2:0] blank;
    logic [2:0] tgt;
    logic       found;
    logic       col0;
    logic       col2;

    // lowest-numbered empty nibble is the blank; scanning downward lets the lowest win
    always_comb begin
        blank = 3'd0;
        found = 1'b0;
        for (int i = NPOS - 1; i >= 0; i--) begin
            if (st[4*i +: 4] == 4'd0) begin
                blank = 3'(i);
                found = 1'b1;
            end
        end
    end

    assign col0  = blank == 3'd0 || blank == 3'd3;
    assign col2  = blank == 3'd2 || blank == 3'd5;
    assign legal = found && (dir == DIR_UP   ? blank >= 3'd3 :
                             dir == DIR_DOWN ? blank <= 3'd2 :
                             dir == DIR_LEFT ? !col0 : !col2);
    assign tgt   = dir == DIR_UP   ? blank - 3'd3 :
                   dir == DIR_DOWN ? blank + 3'd3 :
                   dir == DIR_LEFT ? blank - 3'd1 : blank + 3'd1;

    // neighbour tile moves into the blank's slot and the blank takes its place; top bits pass through
    always_comb begin
        swapped = st;
        if (legal) begin
            swapped[4*blank +: 4] = st[4*tgt +: 4];
            swapped[4*tgt +: 4]   = 4'd0;
        end
    end
endmodule

// File: rtl/puzzle_move_unit.sv
// puzzle_move_unit: executes one blank move on the register-file puzzle state, bumps the counter and scores the result
module puzzle_move_unit
    import puzzle_pkg::*;
#(
    parameter int W    = WORD_W,
    parameter int NPOS = NPOS_C
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mv_valid,
    input  logic [1:0]   mv_dir,
    output logic         mv_ready,
    output logic [3:0]   src0,
    output logic [3:0]   src1,
    output logic [3:0]   dst,
    output logic         we,
    output logic [W-1:0] data,
    input  logic [W-1:0] outa,
    input  logic [W-1:0] outb,
    output logic         illegal,
    output logic         solved,
    output logic         busy
);
    state_t          state;
    logic [W-1:0]    cur_q;
    logic [W-1:0]    ans_q;
    logic [W-1:0]    swapped;
    logic [1:0]      dir_q;
    logic            legal;
    logic [NPOS-1:0] m;

    tile_swap #(.W(W), .NPOS(NPOS)) u_swap (
        .st     (cur_q),
        .dir    (dir_q),
        .swapped(swapped),
        .legal  (legal)
    );

    // per-position agreement between the moved state and the answer
    always_comb begin
        m = '0;
        for (int i = 0; i < NPOS; i++) m[i] = cur_q[4*i +: 4] == ans_q[4*i +: 4];
    end

    assign mv_ready = rst_n && state == ST_IDLE;
    assign busy     = state != ST_IDLE;
    assign src0     = state == ST_COUNT ? REG_COUNTER : REG_CURRENT;
    assign src1     = REG_ANSWER;
    assign dst      = state == ST_COUNT ? REG_COUNTER : state == ST_CMP ? REG_COMPARE : REG_CURRENT;
    assign we       = (state == ST_APPLY && legal) || state == ST_COUNT || state == ST_CMP;
    assign illegal  = state == ST_APPLY && !legal;
    assign data     = state == ST_COUNT ? outa + W'(1) : state == ST_CMP ? W'(m) : swapped;

    // move sequencing: capture operands, apply swap, bump counter, write match bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cur_q  <= '0;
            ans_q  <= '0;
            dir_q  <= DIR_UP;
            solved <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (mv_valid) begin
                    state <= ST_APPLY;
                    cur_q <= outa;
                    ans_q <= outb;
                    dir_q <= mv_dir;
                end
                ST_APPLY: begin
                    state <= legal ? ST_COUNT : ST_IDLE;
                    if (legal) cur_q <= swapped;
                end
                ST_COUNT: state <= ST_CMP;
                ST_CMP: begin
                    solved <= &m;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_puzzle_move_unit.sv
// tb_puzzle_move_unit: register-file environment, grid-level reference model and per-cycle checker
module tb_puzzle_move_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mv_valid = 1'b0;
    logic [1:0]  mv_dir = 2'b00;
    logic        mv_ready, we, illegal, solved, busy;
    logic [3:0]  src0, src1, dst;
    logic [27:0] data, outa, outb;
    logic [27:0] rf [16];
    logic        poke_en = 1'b0;
    logic [3:0]  poke_a = 4'd0;
    logic [27:0] poke_v = 28'd0;
    int tests = 0;
    int fails = 0;
    logic exp_solved = 1'b0;

    typedef struct {
        logic        we;
        logic [3:0]  dst;
        logic [27:0] data;
        logic        ill;
        logic        last;
        logic        sv;
    } step_t;
    step_t q[$];
    step_t st;

    puzzle_move_unit dut (
        .clk(clk), .rst_n(rst_n), .mv_valid(mv_valid), .mv_dir(mv_dir), .mv_ready(mv_ready),
        .src0(src0), .src1(src1), .dst(dst), .we(we), .data(data), .outa(outa), .outb(outb),
        .illegal(illegal), .solved(solved), .busy(busy)
    );

    always #5 clk = ~clk;

    assign outa = rf[src0];
    assign outb = rf[src1];

    always @(posedge clk) begin
        if (we) rf[dst] <= data;
        else if (poke_en) rf[poke_a] <= poke_v;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // grid model: row/column arithmetic on a blank found by scanning; returns {legal, new_state}
    function automatic logic [28:0] model_move(input logic [27:0] s, input logic [1:0] d);
        int b, r, c, nr, nc, t;
        logic [27:0] ns;
        b = -1;
        ns = s;
        for (int p = 0; p < 6; p++) if (b < 0 && s[4*p +: 4] == 4'd0) b = p;
        if (b < 0) return {1'b0, s};
        r = b / 3; c = b % 3; nr = r; nc = c;
        case (d)
            2'b00: nr = r - 1;
            2'b01: nr = r + 1;
            2'b10: nc = c - 1;
            default: nc = c + 1;
        endcase
        if (nr < 0 || nr > 1 || nc < 0 || nc > 2) return {1'b0, s};
        t = nr * 3 + nc;
        ns[4*b +: 4] = s[4*t +: 4];
        ns[4*t +: 4] = 4'd0;
        return {1'b1, ns};
    endfunction

    function automatic logic [5:0] match(input logic [27:0] a, input logic [27:0] b);
        logic [5:0] m;
        for (int p = 0; p < 6; p++) m[p] = a[4*p +: 4] == b[4*p +: 4];
        return m;
    endfunction

    // per-cycle checker: expected write/pulse sequence of each accepted move is queued at acceptance
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_we", we, 0);
            chk("rst_ready", mv_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_illegal", illegal, 0);
            chk("rst_solved", solved, 0);
            q.delete();
            exp_solved = 1'b0;
        end else begin
            chk("solved", solved, exp_solved);
            if (q.size() > 0) begin
                st = q.pop_front();
                chk("busy_ready", {busy, mv_ready}, 2'b10);
                chk("we", we, st.we);
                chk("illegal", illegal, st.ill);
                if (st.we) begin
                    chk("dst", dst, st.dst);
                    chk("data", data, st.data);
                end
                if (st.last) exp_solved = st.sv;
            end else begin
                chk("idle_busy_ready", {busy, mv_ready}, 2'b01);
                chk("idle_we", we, 0);
                chk("idle_illegal", illegal, 0);
                if (mv_valid) begin
                    logic [28:0] r;
                    logic [5:0]  mm;
                    r  = model_move(rf[0], mv_dir);
                    mm = match(r[27:0], rf[1]);
                    if (r[28]) begin
                        q.push_back('{1'b1, 4'd0, r[27:0], 1'b0, 1'b0, 1'b0});
                        q.push_back('{1'b1, 4'd2, rf[2] + 28'd1, 1'b0, 1'b0, 1'b0});
                        q.push_back('{1'b1, 4'd3, {22'b0, mm}, 1'b0, 1'b1, &mm});
                    end else begin
                        q.push_back('{1'b0, 4'd0, 28'd0, 1'b1, 1'b0, 1'b0});
                    end
                end
            end
        end
    end

    task automatic setreg(input logic [3:0] a, input logic [27:0] v);
        poke_a = a; poke_v = v; poke_en = 1'b1;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic move(input logic [1:0] d, output int lat);
        int n;
        n = 0;
        while (!mv_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!mv_ready) chk("ready_timeout", 0, 1);
        mv_valid = 1'b1; mv_dir = d;
        @(posedge clk); #1;
        mv_valid = 1'b0;
        lat = 1;
        while (!mv_ready && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic rand_regs();
        int perm[6];
        logic [27:0] s, a;
        logic [28:0] r;
        for (int i = 0; i < 6; i++) perm[i] = i;
        for (int i = 5; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        s[27:24] = 4'($urandom);
        for (int i = 0; i < 6; i++) s[4*i +: 4] = 4'(perm[i]);
        if ($urandom_range(0, 7) == 0) s = 28'($urandom);
        r = model_move(s, 2'($urandom));
        a = ($urandom_range(0, 1) == 1 && r[28]) ? r[27:0] : 28'($urandom);
        setreg(0, s);
        setreg(1, a);
        setreg(2, $urandom_range(0, 3) == 0 ? 28'hFFFFFFF : 28'($urandom));
    endtask

    initial begin
        int lat, n;
        chk("pin_model_right", model_move(28'hF504321, 2'b11), {1'b1, 28'hF054321});
        chk("pin_model_up", model_move(28'hF504321, 2'b00), {1'b1, 28'hF524301});
        chk("pin_model_down", model_move(28'hF504321, 2'b01), {1'b0, 28'hF504321});
        chk("pin_model_noblank", model_move(28'h0123456 | 28'h1111111, 2'b10) >> 28, 0);
        chk("pin_model_match", match(28'hF524301, 28'hF054321), 6'h0D);
        for (int i = 0; i < 4; i++) setreg(4'(i), 28'd0);
        chk("reset_outputs", {mv_ready, we, busy, illegal, solved}, 5'b0);
        rst_n = 1'b1;
        // legal move to solution
        setreg(0, 28'hF504321); setreg(1, 28'hF054321); setreg(2, 28'd0);
        move(2'b11, lat);
        chk("sol_lat", lat, 4);
        chk("sol_reg0", rf[0], 28'hF054321);
        chk("sol_reg2", rf[2], 28'd1);
        chk("sol_reg3", rf[3], 28'h3F);
        chk("sol_solved", solved, 1);
        // illegal move leaves everything untouched
        setreg(0, 28'hF504321); setreg(2, 28'd5); setreg(3, 28'hAA);
        move(2'b01, lat);
        chk("ill_lat", lat, 2);
        chk("ill_reg0", rf[0], 28'hF504321);
        chk("ill_reg2", rf[2], 28'd5);
        chk("ill_reg3", rf[3], 28'hAA);
        chk("ill_solved", solved, 1);
        // partial match
        move(2'b00, lat);
        chk("part_reg0", rf[0], 28'hF524301);
        chk("part_reg2", rf[2], 28'd6);
        chk("part_reg3", rf[3], 28'h0D);
        chk("part_solved", solved, 0);
        // counter wrap
        setreg(0, 28'hF504321); setreg(2, 28'hFFFFFFF);
        move(2'b10, lat);
        chk("wrap_reg0", rf[0], 28'hF540321);
        chk("wrap_reg2", rf[2], 28'd0);
        // reset while in COUNT
        setreg(0, 28'hF504321); setreg(2, 28'd7);
        mv_valid = 1'b1; mv_dir = 2'b11;
        @(posedge clk); #1; mv_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_we_before", we, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_we_now", {we, busy}, 2'b00);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        chk("midrst_reg2", rf[2], 28'd7);
        chk("midrst_reg0", rf[0], 28'hF054321);
        chk("midrst_solved", solved, 0);
        move(2'b10, lat);
        chk("midrst_next_reg0", rf[0], 28'hF504321);
        chk("midrst_next_reg2", rf[2], 28'd8);
        // back-to-back with mv_valid held
        setreg(2, 28'd0);
        mv_valid = 1'b1; mv_dir = 2'b10;
        @(posedge clk); #1;
        mv_dir = 2'b11;
        n = 0;
        while (!mv_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("b2b_spacing", n + 1, 4);
        @(posedge clk); #1;
        mv_valid = 1'b0;
        chk("b2b_second_busy", busy, 1);
        n = 0;
        while (!mv_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("b2b_reg0", rf[0], 28'hF504321);
        chk("b2b_reg2", rf[2], 28'd2);
        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if (mv_ready && $urandom_range(0, 7) == 0) begin
                mv_valid = 1'b0;
                rand_regs();
            end else begin
                mv_valid = $urandom_range(0, 2) != 0;
                mv_dir = 2'($urandom);
                @(posedge clk); #1;
            end
        end
        mv_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("final_idle", mv_ready, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
